vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Consumes the 25 MHz pixel clock produced by the on-chip PLL and generates 640x480@60 Hz VGA timing: horizontal/vertical counters, active-low sync pulses, pixel-coordinate requests to the frame renderer, and blanked, latency-aligned RGB output to the DAC pins. It sits between the pixel-clock PLL and the game renderer and is the single source of raster timing in the design.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- LATENCY, 1, renderer latency in clocks from pixel_x/pixel_y to rgb_in; legal range 0..4
- COLOR_W, 4, bits per colour channel

Ports:
- clk  in  1  pixel clock, 25 MHz, from PLL output c0
- rst_n  in  1  asynchronous active-low reset
- rgb_in  in  3*COLOR_W  renderer pixel {R,G,B}, valid LATENCY clocks after the matching pixel_x/pixel_y
- pixel_x  out  10  current horizontal count (h_cnt)
- pixel_y  out  10  current vertical count (v_cnt)
- pixel_req  out  1  h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
- frame_start  out  1  one-clock pulse marking h_cnt=0, v_cnt=0
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_rgb  out  3*COLOR_W  {R,G,B} to DAC, zero outside active video

## Operation

- H_TOTAL = 800, V_TOTAL = 525 with defaults (sums of the four parameters each).
- h_cnt increments every clock; at H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1 on the same clock that h_cnt wraps.
- Raw decodes from counters: hs_raw = 0 when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), else 1; vs_raw = 0 when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), else 1; act_raw = pixel_req.
- pixel_x, pixel_y, pixel_req are combinational from the counter registers.
- Alignment pipeline: hs_raw, vs_raw, act_raw pass through a LATENCY-stage shift register (reset to hs=1, vs=1, act=0). Output registers: vga_hs, vga_vs take the delayed sync; vga_rgb <= delayed act ? rgb_in : 0.
- frame_start is a register set on the clock where (h_cnt, v_cnt) = (H_TOTAL-1, V_TOTAL-1), so it is high exactly while counters read (0,0); not asserted for the first frame out of reset.
- Reset values: h_cnt=0, v_cnt=0 (so pixel_x=0, pixel_y=0, pixel_req=1 during reset), frame_start=0, vga_hs=1, vga_vs=1, vga_rgb=0, all pipeline stages inactive.
- Reset asserted mid-frame: all state returns to reset values immediately; after release counting restarts at (0,0) on the first rising edge.

## Timing

- Counter-to-pin latency: LATENCY+1 clocks for hs, vs and rgb; all three are mutually aligned at the pins.
- rgb_in is sampled exactly LATENCY clocks after pixel_x/pixel_y present the coordinate; with LATENCY=0 rgb_in is combinational from pixel_x/pixel_y in the same clock.
- For the first LATENCY+1 clocks after reset release, pins hold reset values.
- Line period 800 clocks (32 us); frame period 420000 clocks (16.8 ms, ~59.5 Hz).
- hsync low 96 clocks per line; vsync low for 2 full lines (1600 clocks), falling coincident with the delayed line start of v_cnt=490.

## Test plan

- Reset: hold rst_n=0 10 clocks with rgb_in=all ones -> vga_hs=1, vga_vs=1, vga_rgb=0, frame_start=0, pixel_x=0, pixel_y=0; deassert -> pixel_x counts 0,1,2...
- Horizontal timing, LATENCY=1: vga_hs falls 658 clocks after release (h_cnt=656 +2), stays low 96 clocks, period 800; pixel_x wraps 799->0 with pixel_y incrementing.
- Vertical/frame: vga_vs low for 1600 clocks starting at line 490 (+2 clocks); frame_start pulses first at clock 420000 after release, then every 420000 clocks; pixel_y wraps 524->0.
- Alignment, LATENCY=1 and LATENCY=3: renderer model returns rgb_in = {pixel_x[3:0], pixel_y[3:0], pixel_x[7:4]} delayed LATENCY -> vga_rgb at each pin position equals the value for the coordinate LATENCY+1 clocks earlier; first visible pixel of line 5 is {0,5,0}.
- Blanking: rgb_in forced to 0xFFF constantly -> vga_rgb=0xFFF for exactly 640 clocks per visible line and 0 elsewhere, including all of lines 480..524.
- Reset mid-frame at (h=300, v=200): rgb and syncs drop to reset values asynchronously; after release first frame_start at clock 420000, timing identical to cold reset.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing from the 25 MHz pixel clock.
// Counters, active-low syncs, renderer coordinates, latency-aligned RGB.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int LATENCY  = 1,
  parameter int COLOR_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3*COLOR_W-1:0]   rgb_in,
  output logic [9:0]             pixel_x,
  output logic [9:0]             pixel_y,
  output logic                   pixel_req,
  output logic                   frame_start,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic [3*COLOR_W-1:0]   vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hs_raw;
  logic       vs_raw;
  logic       act_raw;

  // Index 0 is the undelayed decode; index LATENCY feeds the pins.
  logic [LATENCY:0] hs_sr;
  logic [LATENCY:0] vs_sr;
  logic [LATENCY:0] act_sr;

  // Raster counters: h wraps every line, v wraps with the last line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Registered so the pulse lines up with counters reading (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_start <= 1'b0;
    else        frame_start <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

  // Raw timing decodes straight from the counter registers.
  always_comb begin
    hs_raw    = ~((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_raw    = ~((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    act_raw   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    pixel_x   = h_cnt;
    pixel_y   = v_cnt;
    pixel_req = act_raw;
  end

  assign hs_sr[0]  = hs_raw;
  assign vs_sr[0]  = vs_raw;
  assign act_sr[0] = act_raw;

  generate
    if (LATENCY > 0) begin : g_dly
      // Delay the decodes to match the renderer's pipeline depth.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hs_sr[LATENCY:1]  <= '1;
          vs_sr[LATENCY:1]  <= '1;
          act_sr[LATENCY:1] <= '0;
        end else begin
          hs_sr[LATENCY:1]  <= hs_sr[LATENCY-1:0];
          vs_sr[LATENCY:1]  <= vs_sr[LATENCY-1:0];
          act_sr[LATENCY:1] <= act_sr[LATENCY-1:0];
        end
      end
    end
  endgenerate

  // Pin registers: syncs and blanked colour leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
      vga_rgb <= '0;
    end else begin
      vga_hs  <= hs_sr[LATENCY];
      vga_vs  <= vs_sr[LATENCY];
      vga_rgb <= act_sr[LATENCY] ? rgb_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks on a full-size LATENCY=1 instance
// and a shrunken LATENCY=3 instance for vertical/frame/alignment.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n = 0;
  int   errors = 0;
  int   checks = 0;
  int   ones_cnt = 0;
  int   bad_cnt = 0;

  always #5 clk = ~clk;

  // Full-size instance, renderer drives constant white.
  logic [11:0] rgb0 = 12'hFFF;
  logic [9:0]  px0, py0;
  logic        req0, fs0, hs0, vs0;
  logic [11:0] out0;

  vga_sync_gen u0 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb0),
    .pixel_x(px0), .pixel_y(py0), .pixel_req(req0),
    .frame_start(fs0), .vga_hs(hs0), .vga_vs(vs0),
    .vga_rgb(out0)
  );

  // Small instance: 25 clocks/line, 15 lines/frame, LATENCY=3.
  logic [11:0] rgb1;
  logic [9:0]  px1, py1;
  logic        req1, fs1, hs1, vs1;
  logic [11:0] out1;

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .LATENCY(3), .COLOR_W(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb1),
    .pixel_x(px1), .pixel_y(py1), .pixel_req(req1),
    .frame_start(fs1), .vga_hs(hs1), .vga_vs(vs1),
    .vga_rgb(out1)
  );

  // Renderer model with three clocks of latency.
  logic [11:0] r1 = '0, r2 = '0, r3 = '0;
  always @(posedge clk) begin
    r1 <= {px1[3:0], py1[3:0], px1[7:4]};
    r2 <= r1;
    r3 <= r2;
  end
  assign rgb1 = r3;

  // Tally white pins over the first full line after release.
  always @(negedge clk) begin
    if (rst_n && n >= 2 && n <= 801) begin
      if (out0 == 12'hFFF) ones_cnt++;
      else if (out0 != 12'h000) bad_cnt++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance to edge count t, then sample on the falling edge.
  task automatic to(input int t);
    while (n < t) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1);
    chk("rst_rgb", out0, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_px", px0, 0);
    chk("rst_py", py0, 0);
    chk("rst_req", req0, 1);
    chk("rst_rgb1", out1, 0);
    chk("rst_hs1", hs1, 1);
    rst_n = 1'b1;
    n = 0;

    to(1);
    chk("px_1", px0, 1);
    chk("rgb_hold", out0, 0);
    chk("px1_1", px1, 1);
    to(2);
    chk("px_2", px0, 2);
    chk("rgb_first", out0, 12'hFFF);
    to(3);
    chk("rgb1_hold", out1, 0);
    to(5);
    chk("rgb1_c1", out1, 12'h100);
    to(21);
    chk("hs1_pre", hs1, 1);
    to(22);
    chk("hs1_fall", hs1, 0);
    to(25);
    chk("hs1_last", hs1, 0);
    to(26);
    chk("hs1_rise", hs1, 1);
    to(94);
    chk("rgb1_x15y3", out1, 12'hF30);
    to(95);
    chk("rgb1_blank", out1, 0);
    to(129);
    chk("rgb1_line5", out1, 12'h050);
    to(136);
    chk("rgb1_x7y5", out1, 12'h750);
    to(204);
    chk("rgb1_vblank", out1, 0);
    to(253);
    chk("vs1_pre", vs1, 1);
    to(254);
    chk("vs1_fall", vs1, 0);
    to(303);
    chk("vs1_last", vs1, 0);
    to(304);
    chk("vs1_rise", vs1, 1);
    to(374);
    chk("fs1_pre", fs1, 0);
    chk("py1_last", py1, 14);
    chk("px1_last", px1, 24);
    to(375);
    chk("fs1_first", fs1, 1);
    chk("py1_wrap", py1, 0);
    chk("px1_wrap", px1, 0);
    to(376);
    chk("fs1_pulse", fs1, 0);
    to(641);
    chk("rgb_x639", out0, 12'hFFF);
    to(642);
    chk("rgb_x640", out0, 0);
    to(657);
    chk("hs_pre", hs0, 1);
    to(658);
    chk("hs_fall", hs0, 0);
    to(750);
    chk("fs1_second", fs1, 1);
    to(753);
    chk("hs_last", hs0, 0);
    to(754);
    chk("hs_rise", hs0, 1);
    to(799);
    chk("px_799", px0, 799);
    chk("py_line0", py0, 0);
    to(800);
    chk("px_wrap", px0, 0);
    chk("py_inc", py0, 1);
    to(802);
    chk("white_cnt", ones_cnt, 640);
    chk("bad_cnt", bad_cnt, 0);
    to(1458);
    chk("hs_period", hs0, 0);
    to(1700);
    chk("pre_rgb", out0, 12'hFFF);
    chk("pre_hs1", hs1, 0);

    // Asynchronous reset well inside a frame.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rgb", out0, 0);
    chk("async_hs1", hs1, 1);
    chk("async_px", px0, 0);
    chk("async_py1", py1, 0);
    chk("async_fs", fs0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;

    to(1);
    chk("re_px1", px1, 1);
    to(253);
    chk("re_vs1_pre", vs1, 1);
    to(254);
    chk("re_vs1_fall", vs1, 0);
    to(374);
    chk("re_fs1_pre", fs1, 0);
    to(375);
    chk("re_fs1", fs1, 1);
    to(657);
    chk("re_hs_pre", hs0, 1);
    to(658);
    chk("re_hs_fall", hs0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
